// File: rtl/bht_write_arbiter.sv
// Write-port arbiter for the 64-entry 4-way BHT: ID allocations win, EXE counter updates go direct or via a replay FIFO.
// Optional macro BHT_ARB_STATS_EN adds saturating collision/drop counters.
module bht_write_arbiter #(
  parameter int unsigned QDEPTH  = 4,
  parameter int unsigned IDX_W   = 6,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned ENTRY_W = 20
) (
  input  logic                        CLK,
  input  logic                        nrst,
  input  logic                        en,
  input  logic                        id_alloc_req,
  input  logic [IDX_W-1:0]            id_alloc_idx,
  input  logic [ENTRY_W-1:0]          id_alloc_data,
  input  logic                        exe_upd_req,
  input  logic [IDX_W-1:0]            exe_upd_idx,
  input  logic [TAG_W-1:0]            exe_upd_tag,
  input  logic                        exe_upd_taken,
  output logic [IDX_W-1:0]            bht_rd_idx,
  input  logic [ENTRY_W-1:0]          bht_rd_data,
  output logic                        bht_we,
  output logic [IDX_W-1:0]            bht_wr_idx,
  output logic [ENTRY_W-1:0]          bht_wr_data,
  output logic [$clog2(QDEPTH):0]     q_count,
  output logic                        q_full
`ifdef BHT_ARB_STATS_EN
  ,
  output logic [15:0]                 stat_collisions,
  output logic [15:0]                 stat_drops
`endif
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             taken;
  } upd_t;

  typedef enum logic [1:0] {OCC_EMPTY, OCC_PEND, OCC_FULL} occ_e;

  occ_e            occ_q, occ_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  upd_t            fifo_q [QDEPTH];
  upd_t            fifo_d [QDEPTH];

  upd_t            head;
  upd_t            rmw;
  upd_t            push_word;
  logic            rmw_go;
  logic            push;
  logic            pop;
  logic            accept;
  logic            drop;
  logic            hit;
  logic [1:0]      ctr;

  always_comb begin
    bht_we      = 1'b0;
    bht_wr_idx  = id_alloc_idx;
    bht_wr_data = id_alloc_data;
    bht_rd_idx  = exe_upd_idx;
    push        = 1'b0;
    pop         = 1'b0;
    rmw_go      = 1'b0;
    head        = fifo_q[rd_ptr_q];
    push_word   = '{idx: exe_upd_idx, tag: exe_upd_tag, taken: exe_upd_taken};
    rmw         = push_word;
    hit         = 1'b0;
    ctr         = bht_rd_data[1:0];

    // Writes are gated by reset as well so a reset cycle never commits a half-drained update.
    if (en && nrst) begin
      if (id_alloc_req) begin
        bht_we = 1'b1;
        push   = exe_upd_req;
      end else if (occ_q != OCC_EMPTY) begin
        rmw        = head;
        bht_rd_idx = head.idx;
        rmw_go     = 1'b1;
        pop        = 1'b1;
        push       = exe_upd_req;
      end else if (exe_upd_req) begin
        rmw_go = 1'b1;
      end
    end

    if (rmw_go) begin
      hit        = bht_rd_data[ENTRY_W-1] && (bht_rd_data[ENTRY_W-2 -: TAG_W] == rmw.tag);
      bht_wr_idx = rmw.idx;
      if (hit && rmw.taken && (ctr != 2'b11)) begin
        bht_we      = 1'b1;
        bht_wr_data = {bht_rd_data[ENTRY_W-1:2], ctr + 2'd1};
      end else if (hit && !rmw.taken && (ctr != 2'b00)) begin
        bht_we      = 1'b1;
        bht_wr_data = {bht_rd_data[ENTRY_W-1:2], ctr - 2'd1};
      end
    end
  end

  always_comb begin
    accept   = push && ((occ_q != OCC_FULL) || pop);
    drop     = push && !accept;
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    occ_d    = occ_q;

    if (accept) begin
      fifo_d[wr_ptr_q] = push_word;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (accept && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !accept) begin
      count_d = count_q - CW'(1);
    end

    case (occ_q)
      OCC_EMPTY: if (accept) occ_d = OCC_PEND;
      OCC_PEND: begin
        if (accept && !pop && (count_q == CW'(QDEPTH - 1))) begin
          occ_d = OCC_FULL;
        end else if (pop && !accept && (count_q == CW'(1))) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL:  if (pop && !accept) occ_d = OCC_PEND;
      default:   occ_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nrst) begin
      occ_q    <= OCC_EMPTY;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      occ_q    <= occ_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      fifo_q   <= fifo_d;
    end
  end

  assign q_count = count_q;
  assign q_full  = (occ_q == OCC_FULL);

`ifdef BHT_ARB_STATS_EN
  logic [15:0] stat_coll_q, stat_coll_d;
  logic [15:0] stat_drop_q, stat_drop_d;

  always_comb begin
    stat_coll_d = stat_coll_q;
    stat_drop_d = stat_drop_q;
    if (en && id_alloc_req && exe_upd_req && (stat_coll_q != '1)) begin
      stat_coll_d = stat_coll_q + 16'd1;
    end
    if (drop && (stat_drop_q != '1)) begin
      stat_drop_d = stat_drop_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nrst) begin
      stat_coll_q <= '0;
      stat_drop_q <= '0;
    end else begin
      stat_coll_q <= stat_coll_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign stat_collisions = stat_coll_q;
  assign stat_drops      = stat_drop_q;
`endif

endmodule

// File: tb/tb_bht_write_arbiter.sv
// Bench for bht_write_arbiter: BHT storage model as environment, queue-based reference of the arbitration rules.
module tb_bht_write_arbiter;

  logic        CLK = 1'b0;
  logic        nrst, en;
  logic        id_alloc_req;
  logic [5:0]  id_alloc_idx;
  logic [19:0] id_alloc_data;
  logic        exe_upd_req;
  logic [5:0]  exe_upd_idx;
  logic [5:0]  exe_upd_tag;
  logic        exe_upd_taken;
  logic [5:0]  bht_rd_idx;
  logic [19:0] bht_rd_data;
  logic        bht_we;
  logic [5:0]  bht_wr_idx;
  logic [19:0] bht_wr_data;
  logic [2:0]  q_count;
  logic        q_full;
`ifdef BHT_ARB_STATS_EN
  logic [15:0] stat_collisions, stat_drops;
`endif

  bht_write_arbiter #(.QDEPTH(4), .IDX_W(6), .TAG_W(6), .ENTRY_W(20)) dut (
    .CLK(CLK), .nrst(nrst), .en(en),
    .id_alloc_req(id_alloc_req), .id_alloc_idx(id_alloc_idx), .id_alloc_data(id_alloc_data),
    .exe_upd_req(exe_upd_req), .exe_upd_idx(exe_upd_idx), .exe_upd_tag(exe_upd_tag),
    .exe_upd_taken(exe_upd_taken),
    .bht_rd_idx(bht_rd_idx), .bht_rd_data(bht_rd_data),
    .bht_we(bht_we), .bht_wr_idx(bht_wr_idx), .bht_wr_data(bht_wr_data),
    .q_count(q_count), .q_full(q_full)
`ifdef BHT_ARB_STATS_EN
    , .stat_collisions(stat_collisions), .stat_drops(stat_drops)
`endif
  );

  always #5 CLK = ~CLK;

  // BHT storage the arbiter drives; written only by the DUT write port.
  logic [19:0] tb_mem [64];
  assign bht_rd_data = tb_mem[bht_rd_idx];
  always @(posedge CLK) if (bht_we) tb_mem[bht_wr_idx] <= bht_wr_data;

  typedef struct {
    logic [5:0] idx;
    logic [5:0] tag;
    logic       taken;
  } upd_s;

  upd_s        mq[$];
  logic [19:0] ref_mem [64];
  logic        exp_we, exp_pop, exp_push;
  logic [5:0]  exp_idx;
  logic [19:0] exp_data;
  logic [15:0] exp_coll, exp_drops;
  int          total = 0;
  int          bad = 0;

  task automatic model_rmw(input logic [5:0] idx, input logic [5:0] tag, input logic taken);
    logic [19:0] e;
    int          c;
    e = ref_mem[idx];
    c = int'(e[1:0]);
    if (e[19] === 1'b1 && e[18:13] == tag) begin
      if (taken && c < 3) begin
        exp_we = 1'b1; exp_idx = idx; exp_data = {e[19:2], 2'(c + 1)};
      end else if (!taken && c > 0) begin
        exp_we = 1'b1; exp_idx = idx; exp_data = {e[19:2], 2'(c - 1)};
      end
    end
  endtask

  task automatic model_eval();
    exp_we = 1'b0; exp_idx = '0; exp_data = '0; exp_pop = 1'b0; exp_push = 1'b0;
    if (nrst && en) begin
      if (id_alloc_req) begin
        exp_we = 1'b1; exp_idx = id_alloc_idx; exp_data = id_alloc_data; exp_push = exe_upd_req;
      end else if (mq.size() > 0) begin
        model_rmw(mq[0].idx, mq[0].tag, mq[0].taken);
        exp_pop = 1'b1; exp_push = exe_upd_req;
      end else if (exe_upd_req) begin
        model_rmw(exe_upd_idx, exe_upd_tag, exe_upd_taken);
      end
    end
  endtask

  task automatic model_commit();
    upd_s u;
    if (!nrst) begin
      mq.delete(); exp_coll = '0; exp_drops = '0;
    end else if (en) begin
      if (id_alloc_req && exe_upd_req && exp_coll != 16'hFFFF) exp_coll++;
      if (exp_we) ref_mem[exp_idx] = exp_data;
      if (exp_pop) void'(mq.pop_front());
      if (exp_push) begin
        u.idx = exe_upd_idx; u.tag = exe_upd_tag; u.taken = exe_upd_taken;
        if (mq.size() < 4) mq.push_back(u);
        else if (exp_drops != 16'hFFFF) exp_drops++;
      end
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge CLK);
    model_commit();
    #1;
  endtask

  task automatic idle();
    id_alloc_req = 1'b0; exe_upd_req = 1'b0; en = 1'b1;
  endtask

  task automatic upd(input logic [5:0] idx, input logic [5:0] tag, input logic taken);
    exe_upd_req = 1'b1; exe_upd_idx = idx; exe_upd_tag = tag; exe_upd_taken = taken;
  endtask

  task automatic alloc(input logic [5:0] idx, input logic [19:0] data);
    id_alloc_req = 1'b1; id_alloc_idx = idx; id_alloc_data = data;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [19:0] data);
    idle(); alloc(idx, data); tick(); idle();
  endtask

  task automatic test_reset();
    nrst = 1'b0; idle();
    tick(); tick();
    total++; if (q_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", q_count); end
    total++; if (q_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", q_full); end
    nrst = 1'b1; #2;
    total++; if (bht_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", bht_we); end
    for (int i = 0; i < 64; i++) preload(6'(i), 20'h0);
  endtask

  task automatic test_direct_update();
    preload(6'h05, {1'b1, 6'h12, 11'h040, 2'b01});
    upd(6'h05, 6'h12, 1'b1); #2;
    total++; if (bht_we !== 1'b1 || bht_wr_idx !== 6'h05 || bht_wr_data !== {1'b1, 6'h12, 11'h040, 2'b10}) begin
      bad++; $display("FAIL direct_upd: got we=%b idx=%h data=%h want we=1 idx=05 data=%h",
                      bht_we, bht_wr_idx, bht_wr_data, {1'b1, 6'h12, 11'h040, 2'b10});
    end
    tick(); idle();
    total++; if (q_count !== 3'd0) begin bad++; $display("FAIL direct_count: got %0d want 0", q_count); end
  endtask

  task automatic test_collision();
    alloc(6'h08, {1'b1, 6'h01, 11'h123, 2'b01}); upd(6'h05, 6'h12, 1'b0); #2;
    total++; if (bht_we !== 1'b1 || bht_wr_idx !== 6'h08) begin
      bad++; $display("FAIL coll_alloc: got we=%b idx=%h want we=1 idx=08", bht_we, bht_wr_idx); end
    tick(); idle();
    total++; if (q_count !== 3'd1) begin bad++; $display("FAIL coll_count1: got %0d want 1", q_count); end
    #2;
    total++; if (bht_we !== 1'b1 || bht_wr_idx !== 6'h05 || bht_wr_data !== {1'b1, 6'h12, 11'h040, 2'b01}) begin
      bad++; $display("FAIL coll_drain: got we=%b idx=%h data=%h want we=1 idx=05 data=%h",
                      bht_we, bht_wr_idx, bht_wr_data, {1'b1, 6'h12, 11'h040, 2'b01});
    end
    tick();
    total++; if (q_count !== 3'd0) begin bad++; $display("FAIL coll_count0: got %0d want 0", q_count); end
  endtask

  task automatic test_stale_drop();
    alloc(6'h09, 20'h0); upd(6'h05, 6'h12, 1'b1); tick(); idle();
    alloc(6'h05, {1'b1, 6'h30, 11'h7FF, 2'b01}); tick(); idle();
    total++; if (q_count !== 3'd1) begin bad++; $display("FAIL stale_hold: got %0d want 1", q_count); end
    #2;
    total++; if (bht_we !== 1'b0) begin bad++; $display("FAIL stale_we: got %b want 0", bht_we); end
    tick();
    total++; if (q_count !== 3'd0) begin bad++; $display("FAIL stale_deq: got %0d want 0", q_count); end
  endtask

  task automatic test_saturation();
    preload(6'h0A, {1'b1, 6'h12, 11'h0, 2'b11});
    preload(6'h0B, {1'b1, 6'h12, 11'h0, 2'b00});
    upd(6'h0A, 6'h12, 1'b1); #2;
    total++; if (bht_we !== 1'b0) begin bad++; $display("FAIL sat_hi: got we=%b want 0", bht_we); end
    tick(); upd(6'h0B, 6'h12, 1'b0); #2;
    total++; if (bht_we !== 1'b0) begin bad++; $display("FAIL sat_lo: got we=%b want 0", bht_we); end
    tick(); idle();
  endtask

  task automatic test_enable();
    alloc(6'h10, 20'h0); upd(6'h05, 6'h30, 1'b1); tick(); idle();
    en = 1'b0; alloc(6'h11, 20'hFFFFF); upd(6'h05, 6'h30, 1'b1); #2;
    total++; if (bht_we !== 1'b0) begin bad++; $display("FAIL en_we: got %b want 0", bht_we); end
    tick();
    total++; if (q_count !== 3'd1) begin bad++; $display("FAIL en_hold: got %0d want 1", q_count); end
    idle(); tick();
    total++; if (q_count !== 3'd0) begin bad++; $display("FAIL en_resume: got %0d want 0", q_count); end
  endtask

  task automatic test_full_and_reset();
    nrst = 1'b0; tick(); nrst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      alloc(6'(6'h20 + k), 20'h0); upd(6'h05, 6'h30, 1'b1); #2;
      total++; if (bht_we !== 1'b1 || bht_wr_idx !== 6'(6'h20 + k)) begin
        bad++; $display("FAIL full_alloc%0d: got we=%b idx=%h", k, bht_we, bht_wr_idx); end
      tick();
      total++; if (q_count !== 3'((k < 4) ? k + 1 : 4) || q_full !== (k >= 3)) begin
        bad++; $display("FAIL full_occ%0d: got count=%0d full=%b want count=%0d full=%b",
                        k, q_count, q_full, (k < 4) ? k + 1 : 4, k >= 3);
      end
    end
`ifdef BHT_ARB_STATS_EN
    total++; if (stat_drops !== 16'd2 || stat_collisions !== 16'd6) begin
      bad++; $display("FAIL stats: got drops=%0d coll=%0d want 2 6", stat_drops, stat_collisions); end
`endif
    idle(); tick();
    total++; if (q_count !== 3'd3) begin bad++; $display("FAIL drain_to3: got %0d want 3", q_count); end
    nrst = 1'b0; #2;
    total++; if (bht_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", bht_we); end
    tick(); nrst = 1'b1;
    total++; if (q_count !== 3'd0 || q_full !== 1'b0) begin
      bad++; $display("FAIL rst_mid: got count=%0d full=%b want 0 0", q_count, q_full); end
    #2;
    total++; if (bht_we !== 1'b0) begin bad++; $display("FAIL rst_after_we: got %b want 0", bht_we); end
    tick();
  endtask

  task automatic test_random();
    logic [5:0] tags [4];
    tags[0] = 6'h12; tags[1] = 6'h30; tags[2] = 6'h07; tags[3] = 6'h3F;
    for (int i = 0; i < 64; i++)
      preload(6'(i), {1'($urandom_range(0, 3) != 0), tags[$urandom_range(0, 3)], 11'($urandom), 2'($urandom)});
    for (int n = 0; n < 600; n++) begin
      en = ($urandom_range(0, 9) != 0);
      id_alloc_req = ($urandom_range(0, 3) == 0);
      id_alloc_idx = 6'($urandom);
      id_alloc_data = {1'($urandom_range(0, 3) != 0), tags[$urandom_range(0, 3)], 11'($urandom), 2'($urandom)};
      upd(6'($urandom), tags[$urandom_range(0, 3)], 1'($urandom));
      exe_upd_req = ($urandom_range(0, 2) != 0);
      #2;
      model_eval();
      total++; if (bht_we !== exp_we || (exp_we && (bht_wr_idx !== exp_idx || bht_wr_data !== exp_data))) begin
        bad++; $display("FAIL rand_wr%0d: got we=%b idx=%h data=%h want we=%b idx=%h data=%h",
                        n, bht_we, bht_wr_idx, bht_wr_data, exp_we, exp_idx, exp_data);
      end
      tick();
      total++; if (q_count !== 3'(mq.size()) || q_full !== (mq.size() == 4)) begin
        bad++; $display("FAIL rand_occ%0d: got count=%0d full=%b want %0d %b",
                        n, q_count, q_full, mq.size(), mq.size() == 4);
      end
    end
`ifdef BHT_ARB_STATS_EN
    total++; if (stat_drops !== exp_drops || stat_collisions !== exp_coll) begin
      bad++; $display("FAIL rand_stats: got drops=%0d coll=%0d want %0d %0d",
                      stat_drops, stat_collisions, exp_drops, exp_coll);
    end
`endif
    idle();
  endtask

  initial begin
    nrst = 1'b0; en = 1'b1;
    id_alloc_req = 1'b0; id_alloc_idx = '0; id_alloc_data = '0;
    exe_upd_req = 1'b0; exe_upd_idx = '0; exe_upd_tag = '0; exe_upd_taken = 1'b0;
    exp_coll = '0; exp_drops = '0;
    @(posedge CLK); #1;
    test_reset();
    test_direct_update();
    test_collision();
    test_stale_drop();
    test_saturation();
    test_enable();
    test_full_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bht_write_arbiter.md
Name: bht_write_arbiter

Overview:
- Owns the single write port of the 64-entry, 4-way branch history table.
- Arbitrates between ID-stage allocations (new branch/jump entries) and EXE-stage saturating-counter updates.
- When the two collide, the EXE update is not lost. It is held in a small FIFO and replayed later as a read-modify-write.
- Sits between the predictor's ID/EXE logic and the BHT storage array.

Parameters:
- QDEPTH, 4, depth of the pending-update FIFO (power of 2, ≥2)
- IDX_W, 6, BHT index width ({set[3:0], way[1:0]})
- TAG_W, 6, tag width (entry bits [18:13])
- ENTRY_W, 20, BHT entry width ({valid, tag, target[10:0], ctr[1:0]})

Ports:
- CLK  in  1  clock
- nrst  in  1  synchronous, active-low reset
- en  in  1  pipeline enable; 0 freezes all state and suppresses writes
- id_alloc_req  in  1  ID stage requests an entry allocation
- id_alloc_idx  in  IDX_W  entry index to allocate (FIFO victim)
- id_alloc_data  in  ENTRY_W  full entry to write
- exe_upd_req  in  1  EXE resolved a conditional branch
- exe_upd_idx  in  IDX_W  index of the matching entry
- exe_upd_tag  in  TAG_W  tag of the branch PC (exe_PC[9:4])
- exe_upd_taken  in  1  resolved direction (1 = taken)
- bht_rd_idx  out  IDX_W  combinational read address into the BHT
- bht_rd_data  in  ENTRY_W  combinational read data from the BHT
- bht_we  out  1  BHT write enable; the BHT captures on the next CLK edge
- bht_wr_idx  out  IDX_W  write address
- bht_wr_data  out  ENTRY_W  write data
- q_count  out  $clog2(QDEPTH)+1  number of pending updates
- q_full  out  1  q_count == QDEPTH

Behaviour:
- Reset (nrst=0 at posedge): FIFO empty, rd/wr pointers = 0, q_count = 0, q_full = 0. All combinational outputs evaluate from the empty state: bht_we = 0 unless id_alloc_req.
- Mid-operation reset discards all queued updates; no partial write occurs.
- en=0: bht_we = 0, no pointer or count change, all requests ignored. Upstream holds its requests.
- Write-port priority, one write per cycle:
  - P1: id_alloc_req. bht_wr_idx = id_alloc_idx, bht_wr_data = id_alloc_data, bht_we = 1.
  - P2: FIFO non-empty and no alloc → drain the head.
  - P3: FIFO empty, no alloc, exe_upd_req → direct update, zero added latency.
- Enqueue rules:
  - exe_upd_req enqueues {idx, tag, taken} when the FIFO is non-empty, or when id_alloc_req wins the port. This preserves update ordering.
  - If the FIFO is full and no dequeue happens this cycle, the update is dropped.
  - Enqueue and dequeue in the same cycle is legal: count unchanged, full-plus-drain accepts the new update.
- Read-modify-write for drain (P2) or direct update (P3):
  - bht_rd_idx = head idx (P2), otherwise exe_upd_idx.
  - Let e = bht_rd_data. Apply the update only if e[19]=1 and e[18:13] equals the update tag. Otherwise the entry was replaced: discard, bht_we = 0.
  - taken and e[1:0]≠3 → write e with ctr+1.
  - !taken and e[1:0]≠0 → write e with ctr−1.
  - Counter saturated → no write.
  - In P2 the head is dequeued whether or not a write occurs.
- Ordering hazard: a queued update targeting the same idx as a same-cycle alloc is resolved at drain time by the tag check. No explicit kill logic.
- Pointers wrap modulo QDEPTH.
- q_count, q_full are registered.
- Occupancy states:
  - EMPTY: count=0. Enqueue → PEND.
  - PEND: 0<count<QDEPTH. Enqueue without dequeue reaching QDEPTH → FULL; dequeue to 0 → EMPTY.
  - FULL: count=QDEPTH. Dequeue → PEND; enqueue+dequeue → stay FULL.

Optional Feature:
- Macro: BHT_ARB_STATS_EN.
- Defined: adds outputs stat_collisions[15:0] and stat_drops[15:0].
  - stat_collisions counts cycles with id_alloc_req & exe_upd_req & en.
  - stat_drops counts updates dropped on a full FIFO.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Direct update: FIFO empty, entry idx=6'h05 = {1,6'h12,11'h040,2'b01}; exe_upd_req, taken=1, tag=6'h12 → same-cycle bht_we=1, wr_idx=05, wr_data ctr=2'b10, q_count stays 0.
2. Collision: id_alloc_req idx=6'h08 with exe_upd_req idx=6'h05 taken=0 → cycle 0 writes idx 08, q_count=1. Next cycle drains: idx 05 ctr 10→01, q_count=0.
3. Stale drop: queue an update tag=6'h12 for idx 05, then alloc overwrites idx 05 with tag 6'h30 → on drain bht_we=0 and the entry is dequeued.
4. Saturation: ctr=2'b11 with taken=1, and ctr=2'b00 with taken=0 → bht_we=0 in both cases.
5. Full: hold id_alloc_req high for 6 cycles with exe_upd_req each cycle (QDEPTH=4) → q_full=1 after 4 cycles, 2 updates dropped. With BHT_ARB_STATS_EN defined: stat_drops=2, stat_collisions=6.
6. Reset mid-drain: q_count=3, assert nrst=0 for one cycle → q_count=0, bht_we=0, pointers 0.
